// File: rtl/tone_pkg.sv
// Shared types and constants for the tone/envelope generator: envelope states,
// envelope ceiling and amplitude scaling constants.
package tone_pkg;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_e;

  localparam int ENV_MAX   = 255;
  localparam int VOL_SHIFT = 12;
  localparam int SAMPLE_W  = 16;
  localparam int AMP_W     = SAMPLE_W - 1;

endpackage

// File: rtl/tone_osc.sv
// Square-wave phase generator: phase toggles every 'div' clocks; div of zero
// parks the channel with counter and phase held at zero.
module tone_osc #(
  parameter int DIV_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  output logic             phase,
  output logic             active
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // The >= compare lets a shrinking divisor wrap immediately instead of
  // running the counter all the way around.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (div == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q >= div - 1'b1) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase  = phase_q;
  assign active = (div != '0);

endmodule

// File: rtl/tone_envelope_gen.sv
// Two-channel square-wave source with shared attack/sustain/release envelope,
// 3-bit volume and mute; produces registered signed 16-bit samples every clock.
module tone_envelope_gen
  import tone_pkg::*;
#(
  parameter int DIV_W        = 22,
  parameter int ENV_TICK     = 100000,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       note_on,
  input  logic [DIV_W-1:0]           note_div_left,
  input  logic [DIV_W-1:0]           note_div_right,
  input  logic [2:0]                 volume,
  input  logic                       mute,
  output logic signed [SAMPLE_W-1:0] audio_left,
  output logic signed [SAMPLE_W-1:0] audio_right,
  output logic [1:0]                 env_state
);

  localparam int TICK_W = (ENV_TICK > 1) ? $clog2(ENV_TICK) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(ENV_TICK - 1);

  logic              phase_l, phase_r, active_l, active_r;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              tick;
  env_state_e        state_q, state_d;
  logic [7:0]        env_q, env_d;
  logic [8:0]        env_up, env_dn;
  logic [7:0]        sat_up, sat_dn;
  logic [AMP_W-1:0]  peak, amp;
  logic signed [SAMPLE_W-1:0] mag, sample_l, sample_r;
  logic signed [SAMPLE_W-1:0] audio_left_q, audio_right_q;
  logic              quiet;

  tone_osc #(.DIV_W(DIV_W)) u_osc_left (
    .clk(clk), .rst(rst), .div(note_div_left), .phase(phase_l), .active(active_l)
  );

  tone_osc #(.DIV_W(DIV_W)) u_osc_right (
    .clk(clk), .rst(rst), .div(note_div_right), .phase(phase_r), .active(active_r)
  );

  assign tick   = (tick_q == TICK_LAST);
  assign tick_d = tick ? '0 : tick_q + 1'b1;

  // Steps are computed one bit wider so overflow/underflow can be saturated.
  assign env_up = {1'b0, env_q} + 9'(ATTACK_STEP);
  assign env_dn = {1'b0, env_q} - 9'(RELEASE_STEP);
  assign sat_up = (env_up > 9'(ENV_MAX)) ? 8'(ENV_MAX) : env_up[7:0];
  assign sat_dn = env_dn[8] ? 8'd0 : env_dn[7:0];

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    unique case (state_q)
      ENV_IDLE: begin
        env_d = 8'd0;
        if (note_on) state_d = ENV_ATTACK;
      end
      ENV_ATTACK: begin
        if (tick) env_d = sat_up;
        if (!note_on)                           state_d = ENV_RELEASE;
        else if (tick && sat_up == 8'(ENV_MAX)) state_d = ENV_SUSTAIN;
      end
      ENV_SUSTAIN: begin
        env_d = 8'(ENV_MAX);
        if (!note_on) state_d = ENV_RELEASE;
      end
      ENV_RELEASE: begin
        if (tick) env_d = sat_dn;
        if (note_on)                     state_d = ENV_ATTACK;
        else if (tick && sat_dn == 8'd0) state_d = ENV_IDLE;
      end
      default: state_d = ENV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q  <= '0;
      state_q <= ENV_IDLE;
      env_q   <= 8'd0;
    end else begin
      tick_q  <= tick_d;
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  // amp = (peak * env) >> 8; the low product bits are dropped in the expression.
  assign peak     = {volume, 12'b0};
  assign amp      = AMP_W'((23'(peak) * 23'(env_q)) >> 8);
  assign mag      = {1'b0, amp};
  assign sample_l = phase_l ? mag : -mag;
  assign sample_r = phase_r ? mag : -mag;
  assign quiet    = mute || (state_q == ENV_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      audio_left_q  <= '0;
      audio_right_q <= '0;
    end else begin
      audio_left_q  <= (quiet || !active_l) ? '0 : sample_l;
      audio_right_q <= (quiet || !active_r) ? '0 : sample_r;
    end
  end

  assign audio_left  = audio_left_q;
  assign audio_right = audio_right_q;
  assign env_state   = state_q;

endmodule

// File: tb/tb_tone_envelope_gen.sv
// Bench for tone_envelope_gen: scenario tasks with a cycle-level behavioural
// model of oscillators, envelope and sample scaling.
module tb_tone_envelope_gen;

  localparam int DIV_W = 22;
  localparam int ENV_TICK = 4;

  logic clk = 1'b0;
  logic rst;
  logic note_on;
  logic [DIV_W-1:0] divL, divR;
  logic [2:0] vol;
  logic mute;
  logic signed [15:0] audioL, audioR;
  logic [1:0] envState;

  int total = 0;
  int bad = 0;

  int mTick, mState, mEnv, mCntL, mPhL, mCntR, mPhR, expS;
  logic signed [15:0] expL, expR;

  tone_envelope_gen #(
    .DIV_W(DIV_W), .ENV_TICK(ENV_TICK), .ATTACK_STEP(16), .RELEASE_STEP(4)
  ) dut (
    .clk(clk), .rst(rst), .note_on(note_on),
    .note_div_left(divL), .note_div_right(divR),
    .volume(vol), .mute(mute),
    .audio_left(audioL), .audio_right(audioR), .env_state(envState)
  );

  always #5 clk = ~clk;

  function automatic logic signed [15:0] modelSample(int ph, int d);
    int a;
    if (mute || d == 0 || mState == 0) return 16'sd0;
    a = (int'(vol) * 4096 * mEnv) / 256;
    return ph != 0 ? 16'(a) : 16'(-a);
  endfunction

  task automatic resetModel();
    mTick = 0; mState = 0; mEnv = 0;
    mCntL = 0; mPhL = 0; mCntR = 0; mPhR = 0;
    expL = 0; expR = 0; expS = 0;
  endtask

  task automatic oscStep(input int d, inout int cnt, inout int ph);
    if (d == 0) begin
      cnt = 0; ph = 0;
    end else if (cnt + 1 >= d) begin
      cnt = 0; ph = 1 - ph;
    end else begin
      cnt = cnt + 1;
    end
  endtask

  // Advances the model by one clock using the inputs present at the edge.
  task automatic stepModel();
    bit tick;
    expL = modelSample(mPhL, int'(divL));
    expR = modelSample(mPhR, int'(divR));
    tick = (mTick == ENV_TICK - 1);
    mTick = (mTick + 1) % ENV_TICK;
    oscStep(int'(divL), mCntL, mPhL);
    oscStep(int'(divR), mCntR, mPhR);
    case (mState)
      0: begin
        mEnv = 0;
        if (note_on) mState = 1;
      end
      1: begin
        if (tick) mEnv = (mEnv + 16 > 255) ? 255 : mEnv + 16;
        if (!note_on) mState = 3;
        else if (tick && mEnv == 255) mState = 2;
      end
      2: begin
        mEnv = 255;
        if (!note_on) mState = 3;
      end
      default: begin
        if (tick) mEnv = (mEnv - 4 < 0) ? 0 : mEnv - 4;
        if (note_on) mState = 1;
        else if (tick && mEnv == 0) mState = 0;
      end
    endcase
    expS = mState;
  endtask

  task automatic cycle();
    @(posedge clk);
    stepModel();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; note_on = 1'b0; divL = '0; divR = '0; vol = 3'd0; mute = 1'b0;
    resetModel();
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (audioL !== 16'sd0 || audioR !== 16'sd0 || envState !== 2'd0) begin
        bad++;
        $display("[TB] FAIL reset_init: left=%0d right=%0d state=%0d want 0/0/0", audioL, audioR, envState);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_attack_sustain();
    divL = 22'd5; divR = DIV_W'($urandom_range(1, 20)); vol = 3'd7; note_on = 1'b1;
    for (int i = 0; i < 80; i++) begin
      cycle();
      total++;
      if (audioL !== expL || audioR !== expR || envState !== 2'(expS)) begin
        bad++;
        $display("[TB] FAIL attack cyc%0d: L=%0d/%0d R=%0d/%0d st=%0d/%0d", i, audioL, expL, audioR, expR, envState, expS);
      end
    end
    total++;
    if (envState !== 2'd2 || !(audioL === 16'sh6F90 || audioL === 16'sh9070)) begin
      bad++;
      $display("[TB] FAIL sustain_peak: state=%0d left=%h want 2 and 6f90/9070", envState, audioL);
    end
  endtask

  task automatic test_release();
    note_on = 1'b0;
    cycle();
    total++;
    if (envState !== 2'd3) begin
      bad++;
      $display("[TB] FAIL release_enter: state=%0d want 3", envState);
    end
    for (int i = 0; i < 264; i++) begin
      cycle();
      total++;
      if (audioL !== expL || audioR !== expR || envState !== 2'(expS)) begin
        bad++;
        $display("[TB] FAIL release cyc%0d: L=%0d/%0d R=%0d/%0d st=%0d/%0d", i, audioL, expL, audioR, expR, envState, expS);
      end
    end
    total++;
    if (envState !== 2'd0 || audioL !== 16'sd0 || audioR !== 16'sd0) begin
      bad++;
      $display("[TB] FAIL release_idle: state=%0d L=%0d R=%0d want 0/0/0", envState, audioL, audioR);
    end
  endtask

  task automatic test_retrigger();
    bit found;
    note_on = 1'b1;
    for (int i = 0; i < 80; i++) cycle();
    note_on = 1'b0;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      cycle();
      total++;
      if (audioL !== expL || audioR !== expR || envState !== 2'(expS)) begin
        bad++;
        $display("[TB] FAIL retrig_rel cyc%0d: L=%0d/%0d R=%0d/%0d st=%0d/%0d", i, audioL, expL, audioR, expR, envState, expS);
      end
      if (mState == 3 && mEnv == 131) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL retrig_wait: env 131 not reached in 400 cycles");
      return;
    end
    note_on = 1'b1;
    cycle();
    total++;
    if (envState !== 2'd1) begin
      bad++;
      $display("[TB] FAIL retrig_state: state=%0d want 1", envState);
    end
    for (int i = 0; i < 8 && mEnv != 147; i++) cycle();
    cycle();
    total++;
    if (!(audioL === 16'sd16464 || audioL === -16'sd16464)) begin
      bad++;
      $display("[TB] FAIL retrig_env147: left=%0d want +/-16464", audioL);
    end
  endtask

  task automatic test_mute_silent_channel();
    divR = '0; divL = 22'd8;
    for (int i = 0; i < 60; i++) begin
      cycle();
      total++;
      if (audioL !== expL || audioR !== 16'sd0 || envState !== 2'(expS)) begin
        bad++;
        $display("[TB] FAIL silent_right cyc%0d: L=%0d/%0d R=%0d/0 st=%0d/%0d", i, audioL, expL, audioR, envState, expS);
      end
    end
    mute = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (audioL !== 16'sd0 || audioR !== 16'sd0) begin
        bad++;
        $display("[TB] FAIL mute cyc%0d: L=%0d R=%0d want 0/0", i, audioL, audioR);
      end
    end
    mute = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (audioL !== expL || audioL === 16'sd0) begin
        bad++;
        $display("[TB] FAIL unmute cyc%0d: L=%0d want %0d", i, audioL, expL);
      end
    end
  endtask

  task automatic test_div_change();
    bit found;
    logic signed [15:0] prevL;
    divL = 22'd100; divR = DIV_W'($urandom_range(1, 9));
    found = 0;
    for (int i = 0; i < 220 && !found; i++) begin
      cycle();
      if (mCntL == 50) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL divchg_wait: cnt 50 not reached");
      return;
    end
    prevL = audioL;
    divL = 22'd3;
    cycle();
    cycle();
    total++;
    if (prevL === 16'sd0 || audioL !== -prevL || audioL !== expL) begin
      bad++;
      $display("[TB] FAIL divchg_toggle: left=%0d want %0d (before %0d)", audioL, -prevL, prevL);
    end
  endtask

  task automatic test_volume_zero();
    vol = 3'd0; divL = 22'd4; divR = 22'd6;
    for (int i = 0; i < 20; i++) begin
      cycle();
      total++;
      if (audioL !== 16'sd0 || audioR !== 16'sd0 || audioL !== expL) begin
        bad++;
        $display("[TB] FAIL vol0 cyc%0d: L=%0d R=%0d want 0/0", i, audioL, audioR);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) note_on = ~note_on;
      if ($urandom_range(0, 29) == 0) mute = ~mute;
      if ($urandom_range(0, 24) == 0) vol = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) divL = DIV_W'($urandom_range(0, 12));
      if ($urandom_range(0, 39) == 0) divR = DIV_W'($urandom_range(0, 12));
      cycle();
      total++;
      if (audioL !== expL || audioR !== expR || envState !== 2'(expS)) begin
        bad++;
        $display("[TB] FAIL random cyc%0d: L=%0d/%0d R=%0d/%0d st=%0d/%0d", i, audioL, expL, audioR, expR, envState, expS);
      end
    end
  endtask

  task automatic test_reset_midrun();
    note_on = 1'b1; mute = 1'b0; vol = 3'd7; divL = 22'd3; divR = 22'd5;
    for (int i = 0; i < 20; i++) cycle();
    rst = 1'b1;
    resetModel();
    #1;
    total++;
    if (audioL !== 16'sd0 || audioR !== 16'sd0 || envState !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_async: L=%0d R=%0d st=%0d want 0/0/0", audioL, audioR, envState);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (audioL !== 16'sd0 || audioR !== 16'sd0 || envState !== 2'd0) begin
        bad++;
        $display("[TB] FAIL reset_hold cyc%0d: L=%0d R=%0d st=%0d", i, audioL, audioR, envState);
      end
    end
    rst = 1'b0;
    note_on = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      total++;
      if (audioL !== 16'sd0 || audioR !== 16'sd0 || envState !== 2'(expS)) begin
        bad++;
        $display("[TB] FAIL no_note cyc%0d: L=%0d R=%0d st=%0d want 0/0/%0d", i, audioL, audioR, envState, expS);
      end
    end
  endtask

  initial begin
    test_reset();
    test_attack_sustain();
    test_release();
    test_retrigger();
    test_mute_silent_channel();
    test_div_change();
    test_volume_zero();
    test_random();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
